issue_queue: RTL and testbench

- Unified issue queue (reservation station) directly downstream of the rename stage.
- Buffers renamed micro-ops: physical sources, destination, aluOp, imm, FU class, ROB index.
- Tracks operand readiness via writeback tag broadcasts; issues one ready entry per cycle to execute under a valid/ready handshake.
- Flush empties the queue for branch mispredict recovery.

---
 rtl/issue_queue_pkg.sv | 25 ++
 rtl/iq_priority_select.sv | 16 +
 rtl/issue_queue.sv | 202 ++++++++++++++++++++
 tb/tb_issue_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: default sizing, ALU op classes
// shared with decode, and the per-entry status bits.
package issue_queue_pkg;

    localparam int IQ_DEPTH  = 8;
    localparam int IQ_PREG_W = 6;
    localparam int IQ_ROB_W  = 5;
    localparam int IQ_FU_W   = 2;

    // ALU op classes, same encoding decode produces
    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_LOGIC = 2'd1,
        ALU_SHIFT = 2'd2,
        ALU_CMP   = 2'd3
    } alu_op_e;

    // Width-independent entry state; the only part of an entry that is reset
    typedef struct packed {
        logic valid;
        logic s1_rdy;
        logic s2_rdy;
    } iq_status_t;

endpackage

// File: rtl/iq_priority_select.sv
// Lowest-index one-hot picker, used for free-slot allocation and issue select.
module iq_priority_select #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    // Isolate the lowest set request bit
    always_comb begin
        gnt = req & (~req + N'(1));
        any = |req;
    end

endmodule

// File: rtl/issue_queue.sv
// Unified issue queue: buffers renamed micro-ops, wakes sources on writeback
// broadcasts and issues the lowest-index ready entry each cycle.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH  = IQ_DEPTH,
    parameter int PREG_W = IQ_PREG_W,
    parameter int ROB_W  = IQ_ROB_W,
    parameter int FU_W   = IQ_FU_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  logic [PREG_W-1:0]           disp_sr1_p,
    input  logic [PREG_W-1:0]           disp_sr2_p,
    input  logic [PREG_W-1:0]           disp_dr_p,
    input  logic                        disp_s1_ready,
    input  logic                        disp_s2_ready,
    input  logic [1:0]                  disp_aluOp,
    input  logic [31:0]                 disp_imm,
    input  logic [FU_W-1:0]             disp_FU,
    input  logic [ROB_W-1:0]            disp_ROB_num,
    input  logic                        wb0_valid,
    input  logic [PREG_W-1:0]           wb0_tag,
    input  logic                        wb1_valid,
    input  logic [PREG_W-1:0]           wb1_tag,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [PREG_W-1:0]           issue_sr1_p,
    output logic [PREG_W-1:0]           issue_sr2_p,
    output logic [PREG_W-1:0]           issue_dr_p,
    output logic [1:0]                  issue_aluOp,
    output logic [31:0]                 issue_imm,
    output logic [FU_W-1:0]             issue_FU,
    output logic [ROB_W-1:0]            issue_ROB_num,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PREG_W-1:0] sr1_p;
        logic [PREG_W-1:0] sr2_p;
        logic [PREG_W-1:0] dr_p;
        alu_op_e           alu_op;
        logic [31:0]       imm;
        logic [FU_W-1:0]   fu;
        logic [ROB_W-1:0]  rob_num;
    } payload_t;

    iq_status_t       status_q  [DEPTH];
    iq_status_t       status_d  [DEPTH];
    payload_t         payload_q [DEPTH];
    payload_t         payload_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    // One-hot entry held at the issue port while execute stalls
    logic [DEPTH-1:0] lock_q, lock_d;

    logic [DEPTH-1:0] free_vec, alloc_gnt;
    logic [DEPTH-1:0] rdy_vec, pick_gnt, sel_gnt;
    logic             free_any, pick_any;
    logic             disp_fire, issue_fire;

    function automatic logic tag_hit(
        input logic [PREG_W-1:0] tag,
        input logic              v0,
        input logic [PREG_W-1:0] t0,
        input logic              v1,
        input logic [PREG_W-1:0] t1
    );
        return (v0 && (t0 == tag)) || (v1 && (t1 == tag));
    endfunction

    // Request vectors for allocation (free slots) and select (fully ready)
    always_comb begin
        free_vec = '0;
        rdy_vec  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = ~status_q[i].valid;
            rdy_vec[i]  = status_q[i].valid & status_q[i].s1_rdy & status_q[i].s2_rdy;
        end
    end

    iq_priority_select #(.N(DEPTH)) u_alloc_sel (
        .req (free_vec),
        .gnt (alloc_gnt),
        .any (free_any)
    );

    iq_priority_select #(.N(DEPTH)) u_issue_sel (
        .req (rdy_vec),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Handshake qualification; a stalled selection stays pinned so a
    // lower-index entry waking up cannot change the outputs under execute
    always_comb begin
        disp_ready  = (count_q != CNT_W'(DEPTH));
        sel_gnt     = (|lock_q) ? lock_q : pick_gnt;
        issue_valid = (|lock_q) | pick_any;
        // free_any agrees with count; gating on both protects live entries
        disp_fire   = disp_valid & disp_ready & free_any & ~flush;
        issue_fire  = issue_valid & issue_ready & ~flush;
        lock_d      = '0;
        if (!flush && issue_valid && !issue_ready) begin
            lock_d = sel_gnt;
        end
    end

    // Next entry state: wakeup, issue retire, dispatch write, flush clear
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            status_d[i]  = status_q[i];
            payload_d[i] = payload_q[i];
            if (status_q[i].valid) begin
                if (tag_hit(payload_q[i].sr1_p, wb0_valid, wb0_tag, wb1_valid, wb1_tag)) begin
                    status_d[i].s1_rdy = 1'b1;
                end
                if (tag_hit(payload_q[i].sr2_p, wb0_valid, wb0_tag, wb1_valid, wb1_tag)) begin
                    status_d[i].s2_rdy = 1'b1;
                end
            end
            if (issue_fire && sel_gnt[i]) begin
                status_d[i].valid = 1'b0;
            end
            // Only free slots are allocated, so this never collides with issue
            if (disp_fire && alloc_gnt[i]) begin
                status_d[i].valid  = 1'b1;
                status_d[i].s1_rdy = disp_s1_ready || (disp_sr1_p == '0) ||
                    tag_hit(disp_sr1_p, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
                status_d[i].s2_rdy = disp_s2_ready || (disp_sr2_p == '0) ||
                    tag_hit(disp_sr2_p, wb0_valid, wb0_tag, wb1_valid, wb1_tag);
                payload_d[i].sr1_p   = disp_sr1_p;
                payload_d[i].sr2_p   = disp_sr2_p;
                payload_d[i].dr_p    = disp_dr_p;
                payload_d[i].alu_op  = alu_op_e'(disp_aluOp);
                payload_d[i].imm     = disp_imm;
                payload_d[i].fu      = disp_FU;
                payload_d[i].rob_num = disp_ROB_num;
            end
            if (flush) begin
                status_d[i].valid = 1'b0;
            end
        end
    end

    // Occupancy tracks accepted dispatches minus accepted issues
    always_comb begin
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    // Issue port: one-hot mux of the selected entry, zero when none
    always_comb begin
        issue_sr1_p   = '0;
        issue_sr2_p   = '0;
        issue_dr_p    = '0;
        issue_aluOp   = '0;
        issue_imm     = '0;
        issue_FU      = '0;
        issue_ROB_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_gnt[i]) begin
                issue_sr1_p   = issue_sr1_p   | payload_q[i].sr1_p;
                issue_sr2_p   = issue_sr2_p   | payload_q[i].sr2_p;
                issue_dr_p    = issue_dr_p    | payload_q[i].dr_p;
                issue_aluOp   = issue_aluOp   | payload_q[i].alu_op;
                issue_imm     = issue_imm     | payload_q[i].imm;
                issue_FU      = issue_FU      | payload_q[i].fu;
                issue_ROB_num = issue_ROB_num | payload_q[i].rob_num;
            end
        end
        count = count_q;
    end

    // Control state: valid/ready bits, occupancy and stall lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                status_q[i] <= '0;
            end
            count_q <= '0;
            lock_q  <= '0;
        end else begin
            status_q <= status_d;
            count_q  <= count_d;
            lock_q   <= lock_d;
        end
    end

    // Entry payload storage, qualified by the valid bits and left unreset
    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue with hand-computed expectations.
module tb_issue_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_sr1_p, disp_sr2_p, disp_dr_p;
    logic        disp_s1_ready, disp_s2_ready;
    logic [1:0]  disp_aluOp;
    logic [31:0] disp_imm;
    logic [1:0]  disp_FU;
    logic [4:0]  disp_ROB_num;
    logic        wb0_valid, wb1_valid;
    logic [5:0]  wb0_tag, wb1_tag;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  issue_sr1_p, issue_sr2_p, issue_dr_p;
    logic [1:0]  issue_aluOp;
    logic [31:0] issue_imm;
    logic [1:0]  issue_FU;
    logic [4:0]  issue_ROB_num;
    logic [3:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    issue_queue dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_sr1_p    (disp_sr1_p),
        .disp_sr2_p    (disp_sr2_p),
        .disp_dr_p     (disp_dr_p),
        .disp_s1_ready (disp_s1_ready),
        .disp_s2_ready (disp_s2_ready),
        .disp_aluOp    (disp_aluOp),
        .disp_imm      (disp_imm),
        .disp_FU       (disp_FU),
        .disp_ROB_num  (disp_ROB_num),
        .wb0_valid     (wb0_valid),
        .wb0_tag       (wb0_tag),
        .wb1_valid     (wb1_valid),
        .wb1_tag       (wb1_tag),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_sr1_p   (issue_sr1_p),
        .issue_sr2_p   (issue_sr2_p),
        .issue_dr_p    (issue_dr_p),
        .issue_aluOp   (issue_aluOp),
        .issue_imm     (issue_imm),
        .issue_FU      (issue_FU),
        .issue_ROB_num (issue_ROB_num),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one micro-op for a single edge; payload fields derive from rob
    task automatic put(input logic [5:0] s1, input logic r1,
                       input logic [5:0] s2, input logic r2,
                       input logic [4:0] rob);
        disp_valid    = 1'b1;
        disp_sr1_p    = s1;
        disp_s1_ready = r1;
        disp_sr2_p    = s2;
        disp_s2_ready = r2;
        disp_dr_p     = {1'b1, rob};
        disp_imm      = 32'hA000_0000 | {27'd0, rob};
        disp_FU       = rob[1:0];
        disp_aluOp    = rob[1:0];
        disp_ROB_num  = rob;
        tick();
        disp_valid    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; disp_valid = 1'b0;
        disp_sr1_p = '0; disp_sr2_p = '0; disp_dr_p = '0;
        disp_s1_ready = 1'b0; disp_s2_ready = 1'b0;
        disp_aluOp = '0; disp_imm = '0; disp_FU = '0; disp_ROB_num = '0;
        wb0_valid = 1'b0; wb0_tag = '0; wb1_valid = 1'b0; wb1_tag = '0;
        issue_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset / idle
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_issue_rob", issue_ROB_num, 0);
        tick();
        chk("idle_issue_valid", issue_valid, 0);

        // both sources ready: issues the cycle after dispatch
        issue_ready = 1'b1;
        put(6'd5, 1'b1, 6'd7, 1'b1, 5'd3);
        chk("t2_issue_valid", issue_valid, 1);
        chk("t2_rob", issue_ROB_num, 3);
        chk("t2_sr1", issue_sr1_p, 5);
        chk("t2_sr2", issue_sr2_p, 7);
        chk("t2_dr", issue_dr_p, 6'h23);
        chk("t2_imm", issue_imm, 32'hA000_0003);
        chk("t2_fu", issue_FU, 3);
        chk("t2_aluop", issue_aluOp, 3);
        chk("t2_count", count, 1);
        // dispatch (tag-0 sources) alongside the issue: count unchanged
        put(6'd0, 1'b0, 6'd0, 1'b0, 5'd5);
        chk("t2b_count", count, 1);
        chk("t2b_issue_valid", issue_valid, 1);
        chk("t2b_rob", issue_ROB_num, 5);
        tick();
        chk("t2c_count", count, 0);
        chk("t2c_issue_valid", issue_valid, 0);
        chk("t2c_rob_zero", issue_ROB_num, 0);

        // wakeup two cycles after dispatch
        put(6'd9, 1'b0, 6'd0, 1'b0, 5'd4);
        chk("t3_wait0", issue_valid, 0);
        chk("t3_count", count, 1);
        tick();
        chk("t3_wait1", issue_valid, 0);
        wb0_valid = 1'b1; wb0_tag = 6'd9;
        #1;
        chk("t3_no_same_cycle", issue_valid, 0);
        tick();
        wb0_valid = 1'b0;
        chk("t3_woken", issue_valid, 1);
        chk("t3_rob", issue_ROB_num, 4);
        tick();
        chk("t3_count_done", count, 0);

        // dispatch-cycle bypass from wb1
        wb1_valid = 1'b1; wb1_tag = 6'd12;
        put(6'd12, 1'b0, 6'd13, 1'b1, 5'd6);
        wb1_valid = 1'b0;
        chk("t4_issue_valid", issue_valid, 1);
        chk("t4_rob", issue_ROB_num, 6);
        chk("t4_sr1", issue_sr1_p, 12);
        tick();
        chk("t4_count", count, 0);

        // fill, reject when full, wake entries 2 and 5
        issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put(6'(16 + i), 1'b0, 6'd0, 1'b0, 5'(8 + i));
        end
        chk("t5_count_full", count, 8);
        chk("t5_disp_ready", disp_ready, 0);
        chk("t5_issue_valid", issue_valid, 0);
        put(6'd0, 1'b1, 6'd0, 1'b1, 5'd31);
        chk("t5_reject_count", count, 8);
        chk("t5_reject_issue", issue_valid, 0);
        wb0_valid = 1'b1; wb0_tag = 6'd18;
        wb1_valid = 1'b1; wb1_tag = 6'd21;
        issue_ready = 1'b1;
        tick();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        chk("t5_first_rob", issue_ROB_num, 10);
        chk("t5_first_valid", issue_valid, 1);
        chk("t5_still_full", disp_ready, 0);
        chk("t5_count8", count, 8);
        tick();
        chk("t5_count7", count, 7);
        chk("t5_ready_after", disp_ready, 1);
        chk("t5_second_rob", issue_ROB_num, 13);
        tick();
        chk("t5_count6", count, 6);
        chk("t5_none", issue_valid, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_count", count, 0);
        chk("t5_flush_ready", disp_ready, 1);

        // stall holds selection even when a lower entry wakes, then flush
        issue_ready = 1'b0;
        put(6'd30, 1'b0, 6'd0, 1'b0, 5'd1);
        put(6'd0, 1'b0, 6'd3, 1'b1, 5'd7);
        chk("t6_sel", issue_ROB_num, 7);
        wb0_valid = 1'b1; wb0_tag = 6'd30;
        for (int c = 0; c < 3; c++) begin
            tick();
            wb0_valid = 1'b0;
            chk("t6_hold_valid", issue_valid, 1);
            chk("t6_hold_rob", issue_ROB_num, 7);
            chk("t6_hold_sr2", issue_sr2_p, 3);
            chk("t6_hold_count", count, 2);
        end
        flush = 1'b1;
        issue_ready = 1'b1;
        put(6'd0, 1'b1, 6'd0, 1'b1, 5'd9);
        flush = 1'b0;
        chk("t6_flush_count", count, 0);
        chk("t6_flush_issue", issue_valid, 0);
        tick();
        chk("t6_dropped_issue", issue_valid, 0);
        chk("t6_dropped_count", count, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
